// File: rtl/mnist_conv1_engine_pkg.sv
// mnist_conv1_engine_pkg: shared sizes, FSM states and arithmetic helpers for the conv1 engine
package mnist_conv1_engine_pkg;
  localparam int IMG_W    = 28;
  localparam int K        = 5;
  localparam int OUT_W    = IMG_W - K + 1;
  localparam int PIX_BITS = 8;
  localparam int W_BITS   = 8;
  localparam int ACC_BITS = 21;
  localparam int OUT_BITS = 12;
  localparam int NF       = 3;
  localparam int NT       = K * K;
  localparam int LB_LEN   = (K - 1) * IMG_W + K;
  localparam int CW       = $clog2(IMG_W + 1);
  typedef enum logic [1:0] {SKIP, STREAM, DONE} state_e;
  // Both operands are widened to the accumulator width first so the product is full precision.
  function automatic logic signed [ACC_BITS-1:0] mac_term(input logic [PIX_BITS-1:0] p,
                                                          input logic signed [W_BITS-1:0] w);
    logic signed [ACC_BITS-1:0] pe, we;
    pe = {{(ACC_BITS-PIX_BITS){1'b0}}, p};
    we = {{(ACC_BITS-W_BITS){w[W_BITS-1]}}, w};
    return pe * we;
  endfunction
  // In range when every bit above the output sign bit matches it.
  function automatic logic signed [OUT_BITS-1:0] saturate(input logic signed [ACC_BITS-1:0] x);
    logic [ACC_BITS-OUT_BITS:0] hi;
    hi = x[ACC_BITS-1:OUT_BITS-1];
    return (&hi || ~|hi) ? x[OUT_BITS-1:0] : {x[ACC_BITS-1], {(OUT_BITS-1){~x[ACC_BITS-1]}}};
  endfunction
endpackage

// File: rtl/mnist_conv1_engine_line_buffer.sv
// mnist_conv1_engine_line_buffer: 117-pixel shift register presenting the 5x5 window taps
//   en_i   : shift in pix_i this edge
//   taps_o : window taps, tap i*5+j = pixel (r0+i, c0+j)
//   win_o  : registered strobe, taps hold a complete window
//   last_o : the pixel being sampled now is the last of the frame
module mnist_conv1_engine_line_buffer
  import mnist_conv1_engine_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [PIX_BITS-1:0]           pix_i,
  output logic [NT-1:0][PIX_BITS-1:0]   taps_o,
  output logic                          win_o,
  output logic                          last_o
);
  logic [PIX_BITS-1:0] sr_q [LB_LEN];
  logic [CW-1:0] row_q, col_q;
  logic win_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      win_q <= 1'b0;
    end else begin
      win_q <= en_i && row_q >= CW'(K - 1) && col_q >= CW'(K - 1);
      if (en_i) begin
        col_q <= col_q == CW'(IMG_W - 1) ? '0 : col_q + 1'b1;
        row_q <= col_q == CW'(IMG_W - 1) ? row_q + 1'b1 : row_q;
      end
    end
  always_ff @(posedge clk)
    if (en_i) begin
      sr_q[0] <= pix_i;
      for (int n = 1; n < LB_LEN; n++) sr_q[n] <= sr_q[n-1];
    end
  // sr_q[0] is the newest pixel, so the window's top-left sits at the far end.
  for (genvar i = 0; i < K; i++) begin : g_r
    for (genvar j = 0; j < K; j++) begin : g_c
      assign taps_o[i*K+j] = sr_q[(K-1-i)*IMG_W + (K-1-j)];
    end
  end
  assign win_o  = win_q;
  assign last_o = en_i && row_q == CW'(IMG_W - 1) && col_q == CW'(IMG_W - 1);
endmodule

// File: rtl/mnist_conv1_engine.sv
// mnist_conv1_engine: three 5x5 valid-mode convolutions over a 28x28 pixel stream
//   data_in        : unsigned pixel, raster order, one per clock after the skip period
//   conv_out_1..3  : signed saturated filter results, held between valid pulses
//   valid_out_conv : one pulse per output triple, two edges after the window completes
//   W_INIT         : 75 signed Q1.7 weights, filter f tap t at bits (f*25+t)*8
//   B_INIT         : 3 signed biases in output units, filter f at bits f*12
module mnist_conv1_engine
  import mnist_conv1_engine_pkg::*;
#(
  parameter int                         FRAC_SHIFT  = 7,
  parameter int                         START_DELAY = 1,
  parameter logic [NF*NT*W_BITS-1:0]    W_INIT      = '0,
  parameter logic [NF*OUT_BITS-1:0]     B_INIT      = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PIX_BITS-1:0]           data_in,
  output logic signed [OUT_BITS-1:0]    conv_out_1,
  output logic signed [OUT_BITS-1:0]    conv_out_2,
  output logic signed [OUT_BITS-1:0]    conv_out_3,
  output logic                          valid_out_conv
);
  state_e state_q;
  logic [7:0] skip_q;
  logic en, win, last, v1_q, valid_q;
  logic [NT-1:0][PIX_BITS-1:0] taps;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= START_DELAY == 0 ? STREAM : SKIP;
      skip_q  <= '0;
    end else if (state_q == SKIP) begin
      skip_q  <= skip_q + 8'd1;
      state_q <= skip_q == 8'(START_DELAY - 1) ? STREAM : SKIP;
    end else if (state_q == STREAM && last)
      state_q <= DONE;
  assign en = state_q == STREAM;
  mnist_conv1_engine_line_buffer u_lb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .pix_i  (data_in),
    .taps_o (taps),
    .win_o  (win),
    .last_o (last)
  );
  // Stage 1 registers the adder tree, stage 2 the scaled, biased, saturated result.
  always_ff @(posedge clk)
    if (!rst_n) begin
      v1_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      v1_q    <= win;
      valid_q <= v1_q;
    end
  for (genvar f = 0; f < NF; f++) begin : g_f
    localparam logic [OUT_BITS-1:0] B = B_INIT[f*OUT_BITS +: OUT_BITS];
    logic signed [ACC_BITS-1:0] sum_d, acc_q;
    logic signed [OUT_BITS-1:0] res_d, out_q;
    always_comb begin
      sum_d = '0;
      for (int t = 0; t < NT; t++)
        sum_d = sum_d + mac_term(taps[t], W_INIT[(f*NT+t)*W_BITS +: W_BITS]);
    end
    always_comb res_d = saturate((acc_q >>> FRAC_SHIFT) + $signed({{(ACC_BITS-OUT_BITS){B[OUT_BITS-1]}}, B}));
    always_ff @(posedge clk)
      if (!rst_n) begin
        acc_q <= '0;
        out_q <= '0;
      end else begin
        acc_q <= sum_d;
        if (v1_q) out_q <= res_d;
      end
  end
  assign conv_out_1     = g_f[0].out_q;
  assign conv_out_2     = g_f[1].out_q;
  assign conv_out_3     = g_f[2].out_q;
  assign valid_out_conv = valid_q;
endmodule

// File: tb/tb_mnist_conv1_engine.sv
// tb_mnist_conv1_engine: scoreboard bench running four weight/image configurations side by side
module tb_mnist_conv1_engine;
  localparam logic [599:0] W0 = {75{8'h01}};
  localparam logic [599:0] W1 = 600'(8'h7F) << 96;
  localparam logic [599:0] W2 = {{25{8'h00}}, {25{8'h80}}, {25{8'h7F}}};
  localparam logic [599:0] W3 = 600'(8'h7F) << 32;
  localparam logic [35:0]  B2 = {12'hFFB, 24'h0};
  typedef struct {
    int stamp;
    int a;
    int b;
    int c;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din [4];
  logic signed [11:0] o [4][3];
  logic vo [4];
  int hold [4][3];
  int cnt [4];
  int cyc = 0;
  int cmp = 0;
  int errs = 0;
  exp_t q [4][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mnist_conv1_engine #(
      .W_INIT (g == 0 ? W0 : g == 1 ? W1 : g == 2 ? W2 : W3),
      .B_INIT (g == 2 ? B2 : 36'h0)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (din[g]),
      .conv_out_1     (o[g][0]),
      .conv_out_2     (o[g][1]),
      .conv_out_3     (o[g][2]),
      .valid_out_conv (vo[g])
    );
  end
  function automatic logic [7:0] pix(input int k, input int p);
    case (k)
      0: return 8'd128;
      1: return p == 10*28 + 10 ? 8'd255 : 8'd0;
      2: return 8'd255;
      default: return 8'(p % 28);
    endcase
  endfunction
  function automatic exp_t expect_of(input int k, input int r, input int c, input int stamp);
    exp_t e;
    e.stamp = stamp;
    case (k)
      0: begin e.a = 25; e.b = 25; e.c = 25; end
      1: begin e.a = (r == 8 && c == 8) ? 253 : 0; e.b = 0; e.c = 0; end
      2: begin e.a = 2047; e.b = -2048; e.c = -5; end
      default: begin e.a = c + 3; e.b = 0; e.c = 0; end
    endcase
    return e;
  endfunction
  task automatic chk(input string nm, input int k, input int act, input int req);
    cmp++;
    if (act != req) begin
      errs++;
      $display("FAIL %s inst%0d cycle %0d: got %0d, required %0d", nm, k, cyc, act, req);
    end
  endtask
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      while (q[k].size() > 0 && q[k][0].stamp < cyc) begin
        chk("missed_valid", k, 0, q[k][0].stamp);
        void'(q[k].pop_front());
      end
      if (!rst_n) begin
        chk("reset_valid", k, int'(vo[k]), 0);
        for (int f = 0; f < 3; f++) begin
          chk("reset_out", k, int'(o[k][f]), 0);
          hold[k][f] = 0;
        end
      end else if (vo[k]) begin
        cnt[k]++;
        if (q[k].size() == 0) chk("unexpected_valid", k, 1, 0);
        else begin
          exp_t e;
          e = q[k].pop_front();
          chk("valid_timing", k, cyc, e.stamp);
          chk("out1", k, int'(o[k][0]), e.a);
          chk("out2", k, int'(o[k][1]), e.b);
          chk("out3", k, int'(o[k][2]), e.c);
          hold[k][0] = e.a;
          hold[k][1] = e.b;
          hold[k][2] = e.c;
        end
      end else
        for (int f = 0; f < 3; f++) chk("hold", k, int'(o[k][f]), hold[k][f]);
    end
  end
  task automatic drive_pixel(input int p);
    for (int k = 0; k < 4; k++) begin
      din[k] = pix(k, p);
      if (p / 28 >= 4 && p % 28 >= 4)
        q[k].push_back(expect_of(k, p / 28 - 4, p % 28 - 4, cyc + 3));
    end
    @(negedge clk);
  endtask
  task automatic release_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) din[k] = 8'hAA;
    @(negedge clk);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin
      din[k] = 8'h00;
      cnt[k] = 0;
      for (int f = 0; f < 3; f++) hold[k][f] = 0;
    end
    repeat (3) @(negedge clk);
    release_reset();
    for (int p = 0; p < 400; p++) drive_pixel(p);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    release_reset();
    for (int p = 0; p < 784; p++) drive_pixel(p);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) chk("frame_pulses", k, cnt[k], 576);
    repeat (200) begin
      for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      chk("post_frame_pulses", k, cnt[k], 576);
      chk("queue_drained", k, q[k].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/mnist_conv1_engine.md
Name: mnist_conv1_engine

Overview:
First convolution stage of the MNIST CNN datapath. Accepts a raster-ordered 28x28 stream of unsigned 8-bit pixels, one per clock, with no input handshake. Computes three 5x5 valid-mode convolutions (no flip, stride 1) and emits three 24x24 signed 12-bit feature maps in lock-step, one output triple per valid cycle. Downstream it feeds the 2x2 maxpool/ReLU stage (HALF_WIDTH=12).

Parameters:
IMG_W, 28, input image width and height (square)
K, 5, kernel size
OUT_BITS, 12, output width (signed)
FRAC_SHIFT, 7, arithmetic right shift applied to the accumulator (weights are Q1.7)
START_DELAY, 1, rising edges after reset release whose data_in samples are discarded
W_FILE, "conv1_w.mem", hex file of 75 signed 8-bit weights: filter 0 taps 0..24, then filter 1, then filter 2; tap = i*5+j
B_FILE, "conv1_b.mem", hex file of 3 signed 12-bit biases in output units

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
data_in  in  8  unsigned pixel, raster order (row-major, row 0 first)
conv_out_1  out  12 signed  filter 0 result
conv_out_2  out  12 signed  filter 1 result
conv_out_3  out  12 signed  filter 2 result
valid_out_conv  out  1  high for exactly one cycle per output triple

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk. While low: all outputs 0, valid_out_conv 0, pixel counter 0, line buffer contents don't-care.
- After release, discard the first START_DELAY samples. Every following edge samples one pixel: p = 0..783, row r = p/28, col c = p%28.
- Window with top-left (r0,c0), r0,c0 in 0..23: acc_f = sum over i,j in 0..4 of pixel(r0+i,c0+j) * w_f[i*5+j]. The pixel is zero-extended to 9 bits and multiplied by the 8-bit signed weight. Accumulator is at least 21 bits signed.
- Result_f = saturate_to_12bit((acc_f >>> FRAC_SHIFT) + bias_f). The shift is arithmetic and floors. Saturation limits are +2047 and -2048.
- Window (r0,c0) completes when pixel (r0+4,c0+4) is sampled at edge E. The outputs and valid_out_conv are driven from edge E+2 (fixed 2-cycle pipeline: registered products/adder tree, then registered output).
- valid pattern: 24 consecutive high cycles per row, then 4 low cycles; 24 rows; 576 pulses total, in raster order (r0 outer, c0 inner).
- conv outputs hold their last value while valid is low. Only values qualified by valid are meaningful.
- Line buffer: shift register of (K-1)*IMG_W+K = 117 pixels, taps at offsets row*28+col.
- Single-frame: after pixel 783 the block enters DONE. It ignores data_in, keeps valid low, and stays there until rst_n is asserted.
- States: SKIP (counting START_DELAY) -> STREAM (784 pixels) -> DONE.
- Reset mid-frame aborts immediately. The first valid of the next frame occurs only after a fresh 784-pixel stream.

Decomposition:
- Shared package cnn_pkg: IMG_W, K, OUT_W=24, PIX_BITS=8, W_BITS=8, ACC_BITS=21, OUT_BITS, saturate function.
- One natural sub-module conv_line_buffer: 117-deep pixel shift register exposing the 25 window taps plus the row/col counters and the window-valid strobe.
- The three MAC/adder trees stay as a generate loop in the top.

Test Plan:
- Weights all 0x01, biases 0, pixels all 128: 576 valid pulses. Every output = 25*128=3200>>>7 = 25. The first valid is 2 edges after pixel (4,4) is sampled. Check the 24-high/4-low valid pattern.
- Impulse: pixel(10,10)=255, all other pixels 0. Filter 0 tap 12 = 0x7F, all other weights/biases 0. conv_out_1 = 32385>>>7 = 253 at output (8,8) only, 0 elsewhere. conv_out_2 and conv_out_3 are 0 everywhere.
- Saturation: all pixels 255. Filter 0 weights 0x7F gives +2047 everywhere. Filter 1 weights 0x80 gives -2048 everywhere. Filter 2 weights 0 with bias -5 gives -5 everywhere.
- Orientation: ramp image pixel = c, filter 0 tap 4 = 0x7F (i=0,j=4), others 0. Output (r0,c0) = floor((c0+4)*127/128) = c0+3 for c0 in 0..23, independent of r0.
- Reset at p=400: outputs 0 and valid 0 on the next edge. A restarted full frame yields exactly 576 valid pulses with correct values.
- Post-frame: keep clocking 200 extra cycles with random data_in after pixel 783. valid stays 0 and outputs hold their final values.
